// File: rtl/dynamic_lane_scroller_pkg.sv
// Shared types and constants for the multi-lane scrolling-object generator.
// The optional random spawn feature is enabled by defining DYN_LANE_RANDOM_SPAWN_EN.
package dynamic_lane_pkg;

    // Per-lane life cycle: parked off-screen, scrolling, or waiting to respawn.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        WAIT   = 2'd2
    } lane_state_t;

    localparam int DEFAULT_FRAC_BITS      = 6;
    localparam int FIXED_POINT_MULTIPLIER = 1 << DEFAULT_FRAC_BITS;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit positions 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/dynamic_lane_scroller_lane_mover.sv
// One scrolling lane: state machine, fixed-point position and respawn counter.
// Outputs are registered from the current state, so they trail each update by
// one cycle; the wrap pulse is delayed the same amount to stay aligned with Y.
module lane_mover
    import dynamic_lane_pkg::*;
#(
    parameter int COORD_W       = 11,
    parameter int FRAC_BITS     = DEFAULT_FRAC_BITS,
    parameter int START_Y       = 0,
    parameter int LIMIT_Y       = 479,
    parameter int OFFSCREEN_Y   = 480,
    parameter int RESPAWN_DELAY = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sof,
    input  logic                        pause,
    input  logic                        en,
    input  logic [COORD_W+FRAC_BITS:0]  step,
    input  logic [COORD_W-1:0]          spawn_x,
    output logic signed [COORD_W-1:0]   x_out,
    output logic signed [COORD_W-1:0]   y_out,
    output logic                        active,
    output logic                        wrap_pulse
);

    localparam int POS_W = COORD_W + FRAC_BITS + 1;
    localparam int CNT_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;

    localparam logic signed [POS_W-1:0] START_FP = POS_W'(START_Y * (1 << FRAC_BITS));
    localparam logic signed [POS_W-1:0] LIMIT_FP = POS_W'(LIMIT_Y * (1 << FRAC_BITS));
    localparam logic signed [POS_W-1:0] OFF_FP   = POS_W'(OFFSCREEN_Y * (1 << FRAC_BITS));
    localparam logic signed [COORD_W-1:0] OFF_PIX = COORD_W'(OFFSCREEN_Y);

    lane_state_t               state_q, state_d;
    logic signed [POS_W-1:0]   y_q, y_d;
    logic [COORD_W-1:0]        x_q, x_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      wrap_evt_q, wrap_evt_d;
    logic signed [COORD_W-1:0] x_out_q, x_out_d;
    logic signed [COORD_W-1:0] y_out_q, y_out_d;
    logic                      active_q, active_d;
    logic                      wrap_pulse_q, wrap_pulse_d;
    logic signed [POS_W-1:0]   y_shift;

    // Next state: disable wins, then pause, then the per-frame transition.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        x_d        = x_q;
        cnt_d      = cnt_q;
        wrap_evt_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            y_d     = OFF_FP;
        end else if (sof && !pause) begin
            case (state_q)
                IDLE: begin
                    state_d = MOVING;
                    y_d     = START_FP;
                    x_d     = spawn_x;
                end
                MOVING: begin
                    if (y_q >= LIMIT_FP) begin
                        wrap_evt_d = 1'b1;
                        if (RESPAWN_DELAY == 0) begin
                            y_d = START_FP + $signed(step);
                            x_d = spawn_x;
                        end else begin
                            y_d     = OFF_FP;
                            cnt_d   = CNT_W'(RESPAWN_DELAY - 1);
                            state_d = WAIT;
                        end
                    end else begin
                        y_d = y_q + $signed(step);
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = MOVING;
                        y_d     = START_FP;
                        x_d     = spawn_x;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    y_d     = OFF_FP;
                end
            endcase
        end
    end

    // Output stage: pixel conversion truncates toward minus infinity.
    always_comb begin
        y_shift      = y_q >>> FRAC_BITS;
        y_out_d      = y_shift[COORD_W-1:0];
        x_out_d      = x_q;
        active_d     = (state_q == MOVING);
        wrap_pulse_d = wrap_evt_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            y_q          <= OFF_FP;
            x_q          <= '0;
            cnt_q        <= '0;
            wrap_evt_q   <= 1'b0;
            x_out_q      <= '0;
            y_out_q      <= OFF_PIX;
            active_q     <= 1'b0;
            wrap_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            x_q          <= x_d;
            cnt_q        <= cnt_d;
            wrap_evt_q   <= wrap_evt_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            active_q     <= active_d;
            wrap_pulse_q <= wrap_pulse_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign active     = active_q;
    assign wrap_pulse = wrap_pulse_q;

endmodule

// File: rtl/dynamic_lane_scroller.sv
// Multi-lane scrolling position generator: shared step computation, spawn X
// selection and output packing around NUM_LANES lane_mover instances.
// Define DYN_LANE_RANDOM_SPAWN_EN to randomise spawn X with an LFSR.
module dynamic_lane_scroller
    import dynamic_lane_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int COORD_W        = 11,
    parameter int FRAC_BITS      = DEFAULT_FRAC_BITS,
    parameter int SPEED_W        = 3,
    parameter int BASE_STEP      = 64,
    parameter int STEP_PER_SPEED = 32,
    parameter int START_Y        = 0,
    parameter int LIMIT_Y        = 479,
    parameter int OFFSCREEN_Y    = 480,
    parameter int LANE_PITCH     = 160,
    parameter int RESPAWN_DELAY  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic [SPEED_W-1:0]        speed,
    input  logic                      pause,
    input  logic [NUM_LANES-1:0]      lane_en,
    output logic signed [COORD_W-1:0] coordinate [NUM_LANES][2],
    output logic [NUM_LANES-1:0]      lane_active,
    output logic [NUM_LANES-1:0]      wrap_pulse
);

    localparam int POS_W = COORD_W + FRAC_BITS + 1;

    logic [POS_W-1:0] step;

    // Per-frame step in fixed-point units, from the live speed input.
    always_comb step = POS_W'(BASE_STEP + STEP_PER_SPEED * int'(speed));

`ifdef DYN_LANE_RANDOM_SPAWN_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Advance the spawn LFSR once per unpaused frame.
    always_comb begin
        lfsr_d = lfsr_q;
        if (startOfFrame && !pause) lfsr_d = lfsr_next(lfsr_q);
    end

    // LFSR register, reseeded on reset so spawn sequences are repeatable.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [COORD_W-1:0]        spawn_x;
        logic signed [COORD_W-1:0] x_pix;
        logic signed [COORD_W-1:0] y_pix;
`ifdef DYN_LANE_RANDOM_SPAWN_EN
        logic [15:0] lfsr_mix;

        // Random X inside this lane's column.
        always_comb begin
            lfsr_mix = lfsr_q ^ 16'(i * 16'h1F35);
            spawn_x  = COORD_W'(int'(lfsr_mix) % LANE_PITCH + i * LANE_PITCH);
        end
`else
        // Fixed X at the left edge of this lane's column.
        always_comb spawn_x = COORD_W'(i * LANE_PITCH);
`endif

        lane_mover #(
            .COORD_W       (COORD_W),
            .FRAC_BITS     (FRAC_BITS),
            .START_Y       (START_Y),
            .LIMIT_Y       (LIMIT_Y),
            .OFFSCREEN_Y   (OFFSCREEN_Y),
            .RESPAWN_DELAY (RESPAWN_DELAY)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .sof        (startOfFrame),
            .pause      (pause),
            .en         (lane_en[i]),
            .step       (step),
            .spawn_x    (spawn_x),
            .x_out      (x_pix),
            .y_out      (y_pix),
            .active     (lane_active[i]),
            .wrap_pulse (wrap_pulse[i])
        );

        assign coordinate[i][0] = x_pix;
        assign coordinate[i][1] = y_pix;
    end

endmodule
